// File: rtl/arbiter_types.sv
// Shared types for the I/D cache-to-memory arbiter.
package arbiter_types;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line traffic onto one memory port with
// round-robin on contention and one transaction in flight at a time.
module cache_arbiter
  import arbiter_types::*;
#(
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  icache_pmem_read,
  input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
  output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
  output logic                  icache_pmem_resp,

  input  logic                  dcache_pmem_read,
  input  logic                  dcache_pmem_write,
  input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
  input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
  output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
  output logic                  dcache_pmem_resp,

  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  arb_state_t            state_q, state_d;
  grant_t                last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;

  logic i_req;
  logic d_req;

  assign i_req = icache_pmem_read;
  assign d_req = dcache_pmem_read | dcache_pmem_write;

  // State and captured-command registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= GRANT_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      read_q       <= read_d;
      write_q      <= write_d;
    end
  end

  // Grant decision, capture and completion
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    read_d       = read_q;
    write_d      = write_q;

    unique case (state_q)
      ARB_IDLE: begin
        // I wins when alone, or on contention when D was granted last
        if (i_req && (!d_req || last_grant_q == GRANT_D)) begin
          state_d      = ARB_SERVE_I;
          last_grant_d = GRANT_I;
          addr_d       = icache_pmem_address;
          wdata_d      = '0;
          read_d       = 1'b1;
          write_d      = 1'b0;
        end else if (d_req) begin
          state_d      = ARB_SERVE_D;
          last_grant_d = GRANT_D;
          addr_d       = dcache_pmem_address;
          wdata_d      = dcache_pmem_wdata;
          read_d       = ~dcache_pmem_write;
          write_d      = dcache_pmem_write;
        end
      end
      ARB_SERVE_I, ARB_SERVE_D: begin
        if (pmem_resp) begin
          state_d = ARB_IDLE;
          read_d  = 1'b0;
          write_d = 1'b0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  assign pmem_read    = read_q;
  assign pmem_write   = write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  // Completion is forwarded in the same cycle memory reports it
  assign icache_pmem_resp  = (state_q == ARB_SERVE_I) & pmem_resp;
  assign dcache_pmem_resp  = (state_q == ARB_SERVE_D) & pmem_resp;
  assign icache_pmem_rdata = pmem_rdata;
  assign dcache_pmem_rdata = pmem_rdata;

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter: LINE_WIDTH, default 256, cacheline width in bits.
REQ-002 Parameter: ADDR_WIDTH, default 32, physical address width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: icache_pmem_read  input  1  I-cache line-fill request; held until icache_pmem_resp.
REQ-006 Port: icache_pmem_address  input  ADDR_WIDTH  I-cache line address.
REQ-007 Port: icache_pmem_rdata  output  LINE_WIDTH  line returned to I-cache.
REQ-008 Port: icache_pmem_resp  output  1  I-cache transaction complete.
REQ-009 Port: dcache_pmem_read / dcache_pmem_write  input  1 each  D-cache fill / writeback request; held until dcache_pmem_resp.
REQ-010 Port: dcache_pmem_address  input  ADDR_WIDTH; dcache_pmem_wdata  input  LINE_WIDTH.
REQ-011 Port: dcache_pmem_rdata  output  LINE_WIDTH; dcache_pmem_resp  output  1.
REQ-012 Port: pmem_read, pmem_write  output  1 each  shared memory-port commands.
REQ-013 Port: pmem_address  output  ADDR_WIDTH; pmem_wdata  output  LINE_WIDTH.
REQ-014 Port: pmem_rdata  input  LINE_WIDTH; pmem_resp  input  1  memory transaction complete.

Function
REQ-015 FSM states SHALL be ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D.
REQ-016 ARB_IDLE: only the I-cache requesting -> grant I, go to ARB_SERVE_I; only the D-cache requesting (read or write) -> grant D, go to ARB_SERVE_D; none -> stay.
REQ-017 Simultaneous I and D requests in ARB_IDLE SHALL be granted round-robin: the side not granted last wins; last_grant resets to I, so D wins the first contention.
REQ-018 On grant, address, command (read/write) and wdata of the winner SHALL be captured in registers; pmem_* outputs SHALL be driven only from these registers.
REQ-019 In ARB_SERVE_x, pmem_read or pmem_write (captured command) SHALL be held high until the cycle pmem_resp=1; in ARB_IDLE both SHALL be 0.
REQ-020 On pmem_resp=1 in ARB_SERVE_x, the granted side's *_resp SHALL be 1 that same cycle (combinational), its rdata SHALL equal pmem_rdata, and the FSM SHALL return to ARB_IDLE.
REQ-021 The non-granted side's resp SHALL be 0 throughout; both rdata outputs SHALL be pmem_rdata (valid only with resp).
REQ-022 Latency: request seen in ARB_IDLE at cycle 0 -> pmem command at cycle 1; resp forwarded in the pmem_resp cycle N; next grant decision at cycle N+1 (one idle bubble, mandatory).
REQ-023 A requester dropping its request mid-service SHALL NOT abort the transaction; it completes and the resp is still issued.
REQ-024 dcache_pmem_read and dcache_pmem_write both high SHALL be treated as a write.
REQ-025 pmem_resp while in ARB_IDLE SHALL be ignored (no resp to either cache, no state change).
REQ-026 Requests arriving while in ARB_SERVE_x SHALL wait; no request is lost while held.

Reset
REQ-027 On rst=0 (asynchronous): state=ARB_IDLE, last_grant=I, captured address/wdata/command=0; all pmem_* command outputs and both *_resp outputs SHALL be 0.
REQ-028 Reset during ARB_SERVE_x SHALL abandon the transaction; a later pmem_resp SHALL be ignored per REQ-025.

Structure
REQ-029 Package arbiter_types SHALL hold the arb_state_t enum and a grant_t enum {GRANT_I, GRANT_D}.
REQ-030 No sub-module; FSM, capture registers and output muxing SHALL live in cache_arbiter.

Verification
REQ-031 I-only: icache read addr 0x0000_1000, pmem_resp after 5 cycles with 0xAA..AA -> pmem_read=1 with addr 0x1000 from cycle 1, icache_pmem_resp=1 with rdata 0xAA..AA in the resp cycle, dcache_pmem_resp=0 throughout.
REQ-032 Contention after reset: I read 0x2000 and D write 0x3000 (wdata 0x55..55) in the same cycle -> D served first (pmem_write, 0x3000, 0x55..55), then I served after one idle cycle.
REQ-033 Back-to-back contention: both requests held continuously -> grants alternate D, I, D, I with exactly one ARB_IDLE cycle between transactions.
REQ-034 Mid-service change: D read at 0x4000 granted, then dcache_pmem_address changes to 0x5000 -> pmem_address stays 0x4000 until pmem_resp.
REQ-035 Reset mid-transaction: rst asserted during ARB_SERVE_I -> pmem_read=0 immediately; a pmem_resp after reset release produces no *_resp.
REQ-036 D read and write both high at 0x6000 -> pmem_write=1, pmem_read=0.
